// File: rtl/jstk_spi_poll_arbiter.sv
// Shares one PmodJSTK2 SPI link between two requesters: round-robin grant, 5-byte transaction sequencing, frame decode.
// Latency: grant one cycle after an eligible req; SS low 1500 cyc before the first byte, 1000 cyc between bytes, >=2500 cyc SS high between frames.
// Backpressure: holds eng_start while eng_busy is high; req is level-held by the requester until its done/err pulse.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   req[1:0]             per-requester poll request (level)
//   tx_cmd0/1[39:0]      command bytes, byte0 at [39:32]; sampled on grant
//   gnt/done/err[1:0]    one-hot grant; completion and timeout pulses to the granted requester
//   SS                   JSTK2 slave select, active-low
//   eng_start/eng_tx     byte engine start pulse and byte to send
//   eng_busy/eng_done/eng_rx   byte engine status, done pulse and received byte
//   rx_frame, x_val, y_val, buttons, frame_valid   last good frame and its decoded fields
module jstk_spi_poll_arbiter #(
   parameter int SS_SETUP_CYC  = 1500,
   parameter int BYTE_GAP_CYC  = 1000,
   parameter int FRAME_GAP_CYC = 2500,
   parameter int TIMEOUT_CYC   = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [39:0] tx_cmd0,
   input  logic [39:0] tx_cmd1,
   output logic [1:0]  gnt,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic        SS,
   output logic        eng_start,
   output logic [7:0]  eng_tx,
   input  logic        eng_busy,
   input  logic        eng_done,
   input  logic [7:0]  eng_rx,
   output logic [39:0] rx_frame,
   output logic [9:0]  x_val,
   output logic [9:0]  y_val,
   output logic [2:0]  buttons,
   output logic        frame_valid
);

   localparam int MAX_AB  = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
   localparam int MAX_CD  = (FRAME_GAP_CYC > TIMEOUT_CYC) ? FRAME_GAP_CYC : TIMEOUT_CYC;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   // Load values are trimmed so that the registered edges land exactly the
   // nominal number of cycles apart: the countdown state, the START cycle and
   // the output register each add one cycle on top of the counter.
   localparam logic [CW-1:0] SETUP_LD = CW'(SS_SETUP_CYC - 2);
   localparam logic [CW-1:0] BGAP_LD  = CW'(BYTE_GAP_CYC - 3);
   localparam logic [CW-1:0] TOUT_LD  = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] FGAP_LD  = CW'(FRAME_GAP_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_START, S_WAIT, S_BGAP, S_FIN, S_ABORT
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] gap_cnt, gap_nxt;
   logic [2:0]    byte_idx, idx_nxt;
   logic [39:0]   cmd_q, cmd_nxt;
   logic [31:0]   rx_buf, rxbuf_nxt;      // bytes 0..3; byte 4 arrives straight from eng_rx
   logic          rr_last, rr_nxt;        // index of the requester served last
   logic [1:0]    gnt_nxt, done_nxt, err_nxt;
   logic          ss_nxt, eng_start_nxt, fv_nxt;
   logic [7:0]    eng_tx_nxt;
   logic [39:0]   frame_nxt;
   logic [9:0]    x_nxt, y_nxt;
   logic [2:0]    btn_nxt;
   logic          win;
   logic [39:0]   new_frame;

   // Sole requester wins; on a tie the one not served last wins.
   assign win       = (req == 2'b11) ? ~rr_last : req[1];
   assign new_frame = {rx_buf, eng_rx};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         gap_cnt     <= '0;
         byte_idx    <= '0;
         cmd_q       <= '0;
         rx_buf      <= '0;
         rr_last     <= 1'b1;
         gnt         <= '0;
         done        <= '0;
         err         <= '0;
         SS          <= 1'b1;
         eng_start   <= 1'b0;
         eng_tx      <= '0;
         rx_frame    <= '0;
         x_val       <= '0;
         y_val       <= '0;
         buttons     <= '0;
         frame_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         gap_cnt     <= gap_nxt;
         byte_idx    <= idx_nxt;
         cmd_q       <= cmd_nxt;
         rx_buf      <= rxbuf_nxt;
         rr_last     <= rr_nxt;
         gnt         <= gnt_nxt;
         done        <= done_nxt;
         err         <= err_nxt;
         SS          <= ss_nxt;
         eng_start   <= eng_start_nxt;
         eng_tx      <= eng_tx_nxt;
         rx_frame    <= frame_nxt;
         x_val       <= x_nxt;
         y_val       <= y_nxt;
         buttons     <= btn_nxt;
         frame_valid <= fv_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      gap_nxt       = (gap_cnt != '0) ? gap_cnt - CNT_ONE : gap_cnt;
      idx_nxt       = byte_idx;
      cmd_nxt       = cmd_q;
      rxbuf_nxt     = rx_buf;
      rr_nxt        = rr_last;
      gnt_nxt       = gnt;
      done_nxt      = 2'b00;
      err_nxt       = 2'b00;
      ss_nxt        = SS;
      eng_start_nxt = 1'b0;
      eng_tx_nxt    = eng_tx;
      frame_nxt     = rx_frame;
      x_nxt         = x_val;
      y_nxt         = y_val;
      btn_nxt       = buttons;
      fv_nxt        = 1'b0;

      case (state)
         S_IDLE: begin
            if (gap_cnt == '0 && req != 2'b00) begin
               state_nxt = S_SETUP;
               rr_nxt    = win;
               gnt_nxt   = win ? 2'b10 : 2'b01;
               cmd_nxt   = win ? tx_cmd1 : tx_cmd0;
               ss_nxt    = 1'b0;
               cnt_nxt   = SETUP_LD;
               idx_nxt   = 3'd0;
            end
         end
         S_SETUP: begin
            if (cnt == '0) state_nxt = S_START;
            else           cnt_nxt   = cnt - CNT_ONE;
         end
         S_START: begin
            if (!eng_busy) begin
               state_nxt     = S_WAIT;
               eng_start_nxt = 1'b1;
               eng_tx_nxt    = cmd_q[39:32];
               cmd_nxt       = {cmd_q[31:0], 8'h00};
               cnt_nxt       = TOUT_LD;
            end
         end
         S_WAIT: begin
            if (eng_done) begin
               rxbuf_nxt = new_frame[31:0];
               if (byte_idx == 3'd4) begin
                  // Completion outputs are driven on entry so they are visible during FIN.
                  state_nxt = S_FIN;
                  ss_nxt    = 1'b1;
                  gnt_nxt   = 2'b00;
                  done_nxt  = gnt;
                  fv_nxt    = 1'b1;
                  frame_nxt = new_frame;
                  x_nxt     = {new_frame[25:24], new_frame[39:32]};
                  y_nxt     = {new_frame[9:8],   new_frame[23:16]};
                  btn_nxt   = new_frame[2:0];
                  gap_nxt   = FGAP_LD;
               end else begin
                  state_nxt = S_BGAP;
                  cnt_nxt   = BGAP_LD;
               end
            end else if (cnt == '0) begin
               state_nxt = S_ABORT;
               ss_nxt    = 1'b1;
               gnt_nxt   = 2'b00;
               err_nxt   = gnt;
               gap_nxt   = FGAP_LD;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_BGAP: begin
            if (cnt == '0) begin
               state_nxt = S_START;
               idx_nxt   = byte_idx + 3'd1;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_FIN:   state_nxt = S_IDLE;
         S_ABORT: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_jstk_spi_poll_arbiter.sv
// Bench for jstk_spi_poll_arbiter: directed sequence with random commands/echo bytes,
// a behavioural byte-engine responder and an arbitration/frame reference model.
// Timing is measured as the difference of the cycle indices in which signals are seen asserted.
module tb_jstk_spi_poll_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [39:0] tx_cmd0, tx_cmd1;
   logic [1:0]  gnt, done, err;
   logic        SS, eng_start;
   logic [7:0]  eng_tx;
   logic        eng_busy, eng_done;
   logic [7:0]  eng_rx;
   logic [39:0] rx_frame;
   logic [9:0]  x_val, y_val;
   logic [2:0]  buttons;
   logic        frame_valid;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   int          lst;            // requester served last
   logic [39:0] exp_frame;      // last good frame
   int          last_ss_rise;   // cycle SS went high after the previous frame, -1 if none

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   jstk_spi_poll_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .tx_cmd0(tx_cmd0), .tx_cmd1(tx_cmd1),
      .gnt(gnt), .done(done), .err(err), .SS(SS), .eng_start(eng_start),
      .eng_tx(eng_tx), .eng_busy(eng_busy), .eng_done(eng_done), .eng_rx(eng_rx),
      .rx_frame(rx_frame), .x_val(x_val), .y_val(y_val), .buttons(buttons),
      .frame_valid(frame_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] rnd40();
      return {8'($urandom), 32'($urandom)};
   endfunction

   function automatic int byte_of(input logic [39:0] v, input int k);
      return int'((v >> (8 * (4 - k))) & 40'hFF);
   endfunction

   // Runs one transaction as seen from the requester and the byte engine.
   // hang_at/busy_at/rst_at select a byte index for a fault scenario, -1 for none.
   task automatic serve_txn(input logic [39:0] echo, input int hang_at,
                            input int busy_at, input int rst_at);
      int t, c_s, c_e, c_d, bdrop, lat, who;
      int b[5];
      logic [1:0]  exp_g;
      logic [39:0] cmd;
      logic [7:0]  bt;
      bit bad;
      if (req == 2'b01)      who = 0;
      else if (req == 2'b10) who = 1;
      else                   who = (lst == 0) ? 1 : 0;
      exp_g = (who == 1) ? 2'b10 : 2'b01;
      cmd   = (who == 1) ? tx_cmd1 : tx_cmd0;
      lst   = who;
      c_d   = 0;
      bdrop = 0;

      t = 0;
      while (gnt === 2'b00 && t < 12000) begin @(negedge clk); t++; end
      chk("gnt_wait", t < 12000, 1);
      c_s = cyc;
      chk("gnt", gnt, exp_g);
      chk("ss_low", SS, 0);
      if (last_ss_rise >= 0) chk("frame_gap_min", (c_s - last_ss_rise) >= 2500, 1);

      for (int k = 0; k < 5; k++) begin
         bt = 8'(byte_of(cmd, k));
         if (busy_at == k) begin
            t = (k == 0) ? c_s + 1500 : c_d + 1000;
            while (cyc < t - 20) @(negedge clk);
            eng_busy = 1'b1;
            bad = 0;
            repeat (50) begin @(negedge clk); if (eng_start !== 1'b0) bad = 1; end
            chk("start_held_by_busy", bad, 0);
            eng_busy = 1'b0;
            bdrop = cyc;
         end
         t = 0;
         while (eng_start !== 1'b1 && t < 6000) begin @(negedge clk); t++; end
         chk("start_wait", t < 6000, 1);
         c_e = cyc;
         if (busy_at == k)  chk("start_after_busy", c_e - bdrop, 1);
         else if (k == 0)   chk("ss_setup_cyc", c_e - c_s, 1500);
         else               chk("byte_gap_cyc", c_e - c_d, 1000);
         chk("eng_tx", eng_tx, bt);
         chk("no_partial_leak", rx_frame, exp_frame);

         if (rst_at == k) begin
            repeat (10) @(negedge clk);
            rst = 1'b0;
            #1;
            chk("rst_async_ss", SS, 1);
            chk("rst_async_gnt", gnt, 0);
            return;
         end
         if (hang_at == k) begin
            t = 0;
            while (err === 2'b00 && t < 5000) begin @(negedge clk); t++; end
            chk("err_wait", t < 5000, 1);
            chk("timeout_cyc", cyc - c_e, 4096);
            chk("err", err, exp_g);
            chk("abort_ss", SS, 1);
            chk("abort_gnt", gnt, 0);
            chk("abort_fv", frame_valid, 0);
            chk("abort_frame_kept", rx_frame, exp_frame);
            last_ss_rise = cyc;
            @(negedge clk);
            chk("err_pulse", err, 0);
            return;
         end

         eng_busy = 1'b1;
         bad = 0;
         lat = $urandom_range(2, 12);
         repeat (lat) begin
            @(negedge clk);
            if (eng_tx !== bt || eng_start !== 1'b0) bad = 1;
         end
         chk("eng_tx_stable", bad, 0);
         eng_rx   = 8'(byte_of(echo, k));
         eng_done = 1'b1;
         c_d = cyc;
         @(negedge clk);
         eng_done = 1'b0;
         eng_busy = 1'b0;
      end

      for (int k = 0; k < 5; k++) b[k] = byte_of(echo, k);
      chk("done", done, exp_g);
      chk("frame_valid", frame_valid, 1);
      chk("fin_ss", SS, 1);
      chk("fin_gnt", gnt, 0);
      chk("rx_frame", rx_frame, echo);
      chk("x_val", x_val, (b[1] % 4) * 256 + b[0]);
      chk("y_val", y_val, (b[3] % 4) * 256 + b[2]);
      chk("buttons", buttons, b[4] % 8);
      exp_frame    = echo;
      last_ss_rise = cyc;
      @(negedge clk);
      chk("done_fv_pulse", {done, frame_valid}, 0);
   endtask

   initial begin
      rst = 1'b0; req = 2'b00; tx_cmd0 = '0; tx_cmd1 = '0;
      eng_busy = 1'b0; eng_done = 1'b0; eng_rx = '0;
      lst = 1; exp_frame = '0; last_ss_rise = -1;
      repeat (3) @(negedge clk);
      chk("rst_ss", SS, 1);
      chk("rst_gnt", gnt, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_eng", {eng_start, eng_tx}, 0);
      chk("rst_frame", rx_frame, 0);
      chk("rst_decode", {x_val, y_val, buttons, frame_valid}, 0);
      rst = 1'b1;
      @(negedge clk);

      // spec vector: first request is served immediately, echoed bytes decode
      req = 2'b01;
      @(negedge clk);
      chk("first_grant_immediate", gnt, 2'b01);
      serve_txn(40'hA1_02_B3_01_03, -1, -1, -1);
      chk("vec_x", x_val, 10'h2A1);
      chk("vec_y", y_val, 10'h1B3);
      chk("vec_btn", buttons, 3'b011);
      req = 2'b00;

      // both requesting continuously: grants must alternate
      tx_cmd0 = rnd40(); tx_cmd1 = rnd40();
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         serve_txn(rnd40(), -1, -1, -1);
         tx_cmd0 = rnd40(); tx_cmd1 = rnd40();
      end
      req = 2'b00;

      // requester 1 command sequence, engine busy delays byte 2
      tx_cmd1 = 40'h84_FF_00_00_00;
      req = 2'b10;
      serve_txn(rnd40(), -1, 2, -1);
      req = 2'b00;

      // engine never answers byte 2
      req = 2'b01;
      serve_txn(rnd40(), 2, -1, -1);
      req = 2'b00;

      // reset during byte 3, then immediate service after release
      req = 2'b11;
      serve_txn(rnd40(), -1, -1, 3);
      lst = 1; exp_frame = '0; last_ss_rise = -1;
      eng_busy = 1'b0; eng_done = 1'b0;
      chk("rst_mid_frame_clear", rx_frame, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_release_gnt", gnt, 2'b01);
      serve_txn(rnd40(), -1, -1, -1);
      req = 2'b00;

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
